// File: rtl/iot_event_tx_pkg.sv
// iot_event_tx_pkg: shared sizing helpers and the event tuple for the iot_event_tx slice.
package iot_pkg;
  localparam int N_DEV_DEF = 8;
  localparam int ID_MAX_W = 5;
  function automatic int DEV_ID_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  // dev_id sized for the largest supported N_DEV; the top slices it down
  typedef struct packed {
    logic change;
    logic on_off;
    logic [ID_MAX_W-1:0] dev_id;
  } event_t;
endpackage

// File: rtl/iot_event_tx_if.sv
// iot_event_tx_if: device status inputs and on/off event outputs of iot_event_tx.
interface iot_event_tx_if import iot_pkg::*; #(parameter int N_DEV = N_DEV_DEF);
  logic [N_DEV-1:0] dev_state;
  logic hold;
  logic change;
  logic on_off;
  logic [DEV_ID_W(N_DEV)-1:0] dev_id;
  logic busy;
  modport master(output dev_state, hold, input change, on_off, dev_id, busy);
  modport slave(input dev_state, hold, output change, on_off, dev_id, busy);
endinterface

// File: rtl/iot_event_tx_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the last granted index.
module rr_arbiter import iot_pkg::*; #(
  parameter int N_DEV = N_DEV_DEF,
  localparam int W = DEV_ID_W(N_DEV)
) (
  input  logic [N_DEV-1:0] req_i,
  input  logic [W-1:0]     last_i,
  output logic [N_DEV-1:0] gnt_o,
  output logic [W-1:0]     idx_o,
  output logic             any_o
);
  logic [W-1:0] c;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c = '0;
    for (int k = 1; k <= N_DEV; k++) begin
      c = W'((int'(last_i) + k) % N_DEV);
      if (!any_o && req_i[c]) begin
        any_o = 1'b1;
        idx_o = c;
      end
    end
    gnt_o[idx_o] = any_o;
  end
endmodule

// File: rtl/iot_event_tx.sv
// iot_event_tx: turns device status transitions into one-per-cycle on/off events.
// Optional input debounce is compiled in with IOT_TX_DEBOUNCE_EN.
module iot_event_tx import iot_pkg::*; #(
  parameter int N_DEV = N_DEV_DEF,
  parameter int DEB_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  iot_event_tx_if.slave bus
);
  localparam int W = DEV_ID_W(N_DEV);
  logic [N_DEV-1:0] samp_q, rep_q, rep_d, pending, gnt;
  logic [W-1:0] last_q, idx;
  logic any, grant, busy_q, unused_id;
  event_t ev_q, ev_d;
`ifdef IOT_TX_DEBOUNCE_EN
  logic [7:0] cnt_q [N_DEV];
  logic [7:0] cnt_d [N_DEV];
  logic [N_DEV-1:0] stable;
  // counter clears on the same edge that loads a new value into samp
  always_comb begin
    for (int i = 0; i < N_DEV; i++) begin
      stable[i] = cnt_q[i] == 8'(DEB_CYCLES);
      cnt_d[i] = (bus.dev_state[i] != samp_q[i]) ? 8'd0 : stable[i] ? cnt_q[i] : cnt_q[i] + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < N_DEV; i++) cnt_q[i] <= '0;
    else cnt_q <= cnt_d;
  assign pending = (samp_q ^ rep_q) & stable;
`else
  localparam int unused_deb = DEB_CYCLES;
  assign pending = samp_q ^ rep_q;
`endif
  rr_arbiter #(.N_DEV(N_DEV)) u_arb (
    .req_i(pending), .last_i(last_q), .gnt_o(gnt), .idx_o(idx), .any_o(any)
  );
  always_comb begin
    grant = any & ~bus.hold;
    rep_d = grant ? (rep_q & ~gnt) | (samp_q & gnt) : rep_q;
    ev_d = grant ? {1'b1, samp_q[idx], ID_MAX_W'(idx)} : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      samp_q <= '0;
      rep_q <= '0;
      last_q <= W'(N_DEV - 1);
      ev_q <= '0;
      busy_q <= 1'b0;
    end else begin
      samp_q <= bus.dev_state;
      rep_q <= rep_d;
      last_q <= grant ? idx : last_q;
      ev_q <= ev_d;
      busy_q <= |pending;
    end
  assign bus.change = ev_q.change;
  assign bus.on_off = ev_q.on_off;
  assign bus.dev_id = ev_q.dev_id[W-1:0];
  assign bus.busy = busy_q;
  assign unused_id = ^ev_q.dev_id;
endmodule

// File: tb/tb_iot_event_tx.sv
// tb_iot_event_tx: scoreboard bench; stimulus queues expected events, a monitor checks them.
module tb_iot_event_tx;
  import iot_pkg::*;
  localparam int N = 8;
  localparam int DEB = 4;
`ifdef IOT_TX_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 2;
`endif
  typedef struct {
    logic on;
    int id;
    int at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  iot_event_tx_if #(.N_DEV(N)) bus();
  iot_event_tx #(.N_DEV(N), .DEB_CYCLES(DEB)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int mon_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: consumes every event the DUT presents and tracks the active-device count
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      sb.delete();
      mon_cnt = 0;
    end else if (bus.change) begin
      if (sb.size() == 0) chk("unexpected_event_id", int'(bus.dev_id), -1);
      else begin
        e = sb.pop_front();
        chk("ev_on_off", int'(bus.on_off), int'(e.on));
        chk("ev_dev_id", int'(bus.dev_id), e.id);
        chk("ev_cycle", cyc, e.at);
      end
      mon_cnt += bus.on_off ? 1 : -1;
      pops++;
    end else chk("idle_outputs_zero", int'(bus.on_off) + int'(bus.dev_id), 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic on, input int id, input int at);
    sb.push_back('{on, id, at});
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic drain(input string nm, input int lim);
    int k = 0;
    while (sb.size() != 0 && k < lim) begin
      tick();
      k++;
    end
    chk(nm, sb.size(), 0);
    tick(3);
  endtask

  initial begin
    int c, base, k;
    bus.dev_state = '0;
    bus.hold = 1'b0;
    tick(3);
    chk("reset_change", int'(bus.change), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_dev_id", int'(bus.dev_id), 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_busy", int'(bus.busy), 0);
    end

    bus.dev_state = 8'h04;
    expect_ev(1'b1, 2, cyc + LAT);
    drain("single_on_drain", 40);
    chk("single_on_busy", int'(bus.busy), 0);
    bus.dev_state = 8'h00;
    expect_ev(1'b0, 2, cyc + LAT);
    drain("single_off_drain", 40);
    chk("single_count", mon_cnt, 0);

    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    bus.dev_state = 8'hFF;
    c = cyc;
    for (int i = 0; i < 8; i++) expect_ev(1'b1, i, c + LAT + i);
    wait_until(c + LAT + 7);
    chk("burst_busy_last", int'(bus.busy), 1);
    tick();
    chk("burst_busy_drop", int'(bus.busy), 0);
    drain("burst_on_drain", 40);
    chk("burst_on_count", mon_cnt, 8);
    bus.dev_state = 8'h00;
    c = cyc;
    for (int i = 0; i < 8; i++) expect_ev(1'b0, i, c + LAT + i);
    drain("burst_off_drain", 60);
    chk("burst_off_count", mon_cnt, 0);

    bus.hold = 1'b1;
    bus.dev_state = 8'h81;
    tick(10);
    chk("hold_busy", int'(bus.busy), 1);
    chk("hold_change", int'(bus.change), 0);
    bus.hold = 1'b0;
    c = cyc;
    expect_ev(1'b1, 0, c + 1);
    expect_ev(1'b1, 7, c + 2);
    drain("hold_drain", 40);
    chk("hold_count", mon_cnt, 2);

    bus.hold = 1'b1;
    bus.dev_state = 8'h89;
    tick(2);
    bus.dev_state = 8'h81;
    tick(3);
    bus.hold = 1'b0;
    tick(10);
    chk("cancel_busy", int'(bus.busy), 0);
    chk("cancel_no_event", sb.size(), 0);
    chk("cancel_count", mon_cnt, 2);

`ifdef IOT_TX_DEBOUNCE_EN
    bus.dev_state = 8'hA1;
    tick(2);
    bus.dev_state = 8'h81;
    tick(15);
    chk("glitch_busy", int'(bus.busy), 0);
    chk("glitch_count", mon_cnt, 2);
`endif

    bus.dev_state = 8'h00;
    c = cyc;
    expect_ev(1'b0, 0, c + LAT);
    expect_ev(1'b0, 7, c + LAT + 1);
    drain("pre_reset_drain", 40);
    chk("pre_reset_count", mon_cnt, 0);
    bus.dev_state = 8'hFF;
    c = cyc;
    base = pops;
    for (int i = 0; i < 8; i++) expect_ev(1'b1, i, c + LAT + i);
    k = 0;
    while (pops < base + 3 && k < 40) begin
      tick();
      k++;
    end
    chk("mid_drain_pulses", pops - base, 3);
    rst = 1'b0;
    #1;
    chk("mid_reset_change", int'(bus.change), 0);
    chk("mid_reset_busy", int'(bus.busy), 0);
    tick(2);
    chk("mid_reset_flushed", sb.size(), 0);
    rst = 1'b1;
    c = cyc;
    for (int i = 0; i < 8; i++) expect_ev(1'b1, i, c + LAT + i);
    drain("post_reset_drain", 60);
    chk("post_reset_count", mon_cnt, 8);
    chk("post_reset_busy", int'(bus.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iot_event_tx.md
# iot_event_tx

Transmit side of the device on/off event interface. The block watches the on/off status lines of up to N_DEV IoT devices and turns every status transition into a one-cycle `change` pulse with `on_off` giving the new state, the format the active-device monitor counts. At most one event is issued per cycle; simultaneous transitions are queued and served round-robin, so the count of devices reported on never drifts from the true count.

## Interface

- `N_DEV`, default 8: number of device status lines, 2..32.
- `DEB_CYCLES`, default 4: stability window in clocks, used only when debounce is compiled in, 1..255.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset (0 = reset).
- `dev_state` input, N_DEV bits: level per device, 1 = on; may change on any cycle.
- `hold` input, 1 bit: 1 stalls event issue, and pending transitions are kept.
- `change` output, 1 bit: registered one-cycle event strobe.
- `on_off` output, 1 bit: new state of the reported device. Valid when `change`=1, otherwise 0.
- `dev_id` output, $clog2(N_DEV) bits: index of the reported device. Valid when `change`=1, otherwise 0.
- `busy` output, 1 bit: registered; 1 while any transition is pending.

## Operation

- **Input registers:**
  - `samp` registers `dev_state` every cycle.
  - `rep` holds the last reported state per device.
  - `pending[i]` = `samp[i]` ^ `rep[i]`; qualified by debounce if enabled.
- **Grant:** each cycle with `hold`=0 and any pending bit set, one device is granted by round-robin.
  - Search starts at `last+1` mod N_DEV and wraps at N_DEV-1 → 0.
  - `last` updates to the granted index.
- **On grant:** `change`<=1, `on_off`<=`samp[g]`, `dev_id`<=g, `rep[g]`<=`samp[g]`.
- **No grant:** `change`, `on_off` and `dev_id` are all set to 0.
- **Cancelled transition:** a device that toggles and returns before it is granted leaves no pending bit and produces no event. The net count is still correct.
- **Back-to-back events:** allowed every cycle. N simultaneous transitions drain in N consecutive cycles.
- **`busy`** is the registered OR of `pending`.
- **Invariant:** popcount(`rep`) equals the monitor count mod 256 when both blocks leave reset together with all devices off.
- **Reset values:** `samp`=0, `rep`=0, `last`=N_DEV-1 (first search starts at device 0), `change`=0, `on_off`=0, `dev_id`=0, `busy`=0, debounce counters=0.
- **Reset mid-operation:** all pending events are discarded. After release, devices that are on are re-reported as on-events.

## Timing

- `dev_state` is sampled at edge t.
- Pending is visible combinationally after edge t.
- With no contention and `hold`=0, `change` asserts after edge t+1, giving 2-cycle latency.
- `hold` is sampled at the grant edge: `hold`=1 at edge t+1 means `change`=0 after that edge.
- `busy` lags `pending` by one cycle.
- Worst-case latency without hold is 2 + (N_DEV-1) cycles.

## Configuration

- **`IOT_TX_DEBOUNCE_EN` defined:**
  - Each device has a counter that resets to 0 whenever `samp[i]` differs from its previous value.
  - The counter otherwise increments, saturating at DEB_CYCLES.
  - `pending[i]` also requires counter == DEB_CYCLES.
  - Added latency is DEB_CYCLES cycles.
  - Pulses shorter than DEB_CYCLES+1 cycles produce no events.
- **Not defined:** no counters; `pending` is the raw XOR; `DEB_CYCLES` is ignored.

## Structure

- **Shared package `iot_pkg`:**
  - default N_DEV;
  - `DEV_ID_W` function ($clog2 with a minimum of 1);
  - the typedef for the event tuple {change, on_off, dev_id}.
- **Sub-module `rr_arbiter`:**
  - inputs: request vector and `last` pointer;
  - outputs: one-hot grant, encoded index, `any`;
  - combinational, parameterised by N_DEV.
- `iot_event_tx` holds the registers, the debounce logic and the output stage.

## Test plan

1. Reset with `rst`=0, `dev_state`=0, then release. Hold `dev_state`=0 for 20 cycles → `change`=0 and `busy`=0 throughout.
2. Single event: `dev_state` goes from 0x00 to 0x04 → exactly 2 cycles later a single pulse with `change`=1, `on_off`=1, `dev_id`=2. Returning to 0x00 gives one pulse with `on_off`=0, `dev_id`=2.
3. Simultaneous: `dev_state` goes from 0x00 to 0xFF → 8 consecutive pulses with `dev_id` 0,1,…,7 and `on_off`=1. `busy` drops one cycle after the last pulse.
4. Hold: set 0x81 with `hold`=1 for 10 cycles → no pulses and `busy`=1. Release `hold` → `dev_id` 0 then 7.
5. Cancelled transition: with `hold`=1, toggle device 3 on then off, then release `hold` → no event. A monitor model counts 0.
6. Reset mid-drain: assert `rst` during case 3 after 3 pulses, then release with 0xFF still applied → 8 fresh pulses starting at `dev_id` 0.
   - With `IOT_TX_DEBOUNCE_EN`: a 2-cycle glitch on device 5 with DEB_CYCLES=4 → no event.
